// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter.
//   rx_state_t  : receiver FSM state encoding
//   DATA_BITS   : payload bits per frame
//   FRAME_BITS  : start + data + parity + stop
//   calc_parity : parity bit a transmitter would attach to a byte
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // Returns the parity bit that makes the frame's total parity match `even`.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
//------------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line.
//   CLK  : system clock
//   rst  : asynchronous active-high reset (flops reset to line-idle 1)
//   din  : asynchronous serial input
//   dout : synchronised copy, two cycles of latency
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic CLK,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Reset to 1 so a released reset never looks like a start bit.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops update from the
            // pre-edge values, giving a true two-stage shift.
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fc.sv
//------------------------------------------------------------------------------
// uart_rx_fc
// UART receiver (start, 8 data LSB-first, parity, stop) with a one-byte
// holding register and RTS flow control toward the far-end transmitter.
//   CLK        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   serial_in  : asynchronous serial line, idles high
//   rd_en      : consumer pops the held byte (ignored while empty)
//   data_out   : held received byte
//   data_valid : data_out holds an unread byte
//   parity_err : parity mismatch on the held byte
//   frame_err  : stop bit was 0 on the held byte
//   overrun    : sticky, a frame completed while the buffer was full
//   RTS        : registered ready-to-receive, equals !data_valid
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_fc
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EVEN  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 RTS
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   rxs;

    logic [CW-1:0]          cnt_max;
    logic                   tick;
    logic                   cnt_clr, idx_clr;
    logic                   data_smp, par_smp, frame_done;
    logic                   pop, load, drop, dv_d;

    uart_rx_sync u_sync (
        .CLK  (CLK),
        .rst  (rst),
        .din  (serial_in),
        .dout (rxs)
    );

    // The start bit is timed to its middle; every later bit is one full
    // bit period after the previous sample, so all samples land mid-bit.
    assign cnt_max = (state_q == START) ? CW'(CLKS_PER_BIT/2 - 1) : CW'(CLKS_PER_BIT - 1);
    assign tick    = (cnt_q == cnt_max);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_clr    = 1'b0;
        idx_clr    = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                    state_d = rxs ? IDLE : DATA;   // high at mid-bit: glitch
                end
            end
            DATA: begin
                if (tick) begin
                    data_smp = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_idx_q == IW'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_smp = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    cnt_clr    = 1'b1;
                    state_d    = IDLE;   // ready for a back-to-back start bit
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the completion cycle frees the slot, so the new byte is taken.
    always_comb begin
        pop  = rd_en & data_valid;
        load = frame_done & (~data_valid | rd_en);
        drop = frame_done & data_valid & ~rd_en;
        dv_d = load ? 1'b1 : (pop ? 1'b0 : data_valid);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            RTS        <= 1'b0;
        end else begin
            if (cnt_clr || state_q == IDLE) cnt_q <= '0;
            else                            cnt_q <= cnt_q + 1'b1;

            if (idx_clr)       bit_idx_q <= '0;
            else if (data_smp) bit_idx_q <= bit_idx_q + 1'b1;

            if (data_smp) shift_q[bit_idx_q] <= rxs;
            if (par_smp)  parity_q           <= rxs;

            data_valid <= dv_d;
            RTS        <= ~dv_d;

            if (load) begin
                data_out   <= shift_q;
                parity_err <= (parity_q != calc_parity(shift_q, PARITY_EVEN));
                frame_err  <= ~rxs;
            end

            if (drop)     overrun <= 1'b1;
            else if (pop) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fc.sv
//------------------------------------------------------------------------------
// tb_uart_rx_fc
// Directed self-checking bench for uart_rx_fc with CLKS_PER_BIT = 4.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fc;
    import uart_pkg::*;

    localparam int CPB = 4;
    // Edges from the first edge that sees the start bit until data_valid.
    localparam int LAT = 2 + CPB/2 + (FRAME_BITS - 1)*CPB + 1;

    logic       CLK = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       RTS;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fc #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EVEN  (1'b1)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .serial_in  (serial_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .RTS        (RTS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame starting at the current negedge; returns at the
    // negedge after the last bit period with the line back at idle.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        logic [FRAME_BITS-1:0] line;
        line = {stop, par, data, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) begin
            serial_in = line[i];
            repeat (CPB) @(negedge CLK);
        end
        serial_in = 1'b1;
    endtask

    // data_valid must be low one edge before LAT and high right after it.
    task automatic expect_arrival(input string tag);
        repeat (LAT - FRAME_BITS*CPB - 1) @(negedge CLK);
        check({tag, "_early"}, data_valid, 1'b0);
        @(negedge CLK);
        check({tag, "_due"}, data_valid, 1'b1);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Bench-side transmitter: waits for CTS (our RTS), sends with even parity.
    task automatic tx_fc(input logic [7:0] data, input string tag);
        int waited;
        waited = 0;
        while (RTS !== 1'b1 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_cts"}, RTS, 1'b1);
        send_frame(data, ^data, 1'b1);
        expect_arrival(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        serial_in = 1'b1;
        rd_en     = 1'b0;
        idle(2);

        // Reset state
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_rts", RTS, 1'b0);
        rst = 1'b0;
        @(negedge CLK);
        check("rts_after_release", RTS, 1'b1);
        idle(2);

        // 1. Basic byte 0x6B: line 0,1,1,0,1,0,1,1,0,1,1
        send_frame(8'h6B, 1'b1, 1'b1);
        expect_arrival("b1");
        check("b1_data", data_out, 8'h6B);
        check("b1_perr", parity_err, 1'b0);
        check("b1_ferr", frame_err, 1'b0);
        check("b1_rts", RTS, 1'b0);
        pop();
        check("b1_pop_valid", data_valid, 1'b0);
        check("b1_pop_rts", RTS, 1'b1);
        idle(4);

        // 2a. 0x00 with wrong parity bit 1
        send_frame(8'h00, 1'b1, 1'b1);
        expect_arrival("e1");
        check("e1_data", data_out, 8'h00);
        check("e1_perr", parity_err, 1'b1);
        check("e1_ferr", frame_err, 1'b0);
        pop();
        idle(4);

        // 2b. 0xFF with correct parity 0 and stop bit 0
        send_frame(8'hFF, 1'b0, 1'b0);
        expect_arrival("e2");
        check("e2_data", data_out, 8'hFF);
        check("e2_perr", parity_err, 1'b0);
        check("e2_ferr", frame_err, 1'b1);
        pop();
        idle(8);

        // 3. One-cycle glitch is rejected as a false start
        serial_in = 1'b0;
        @(negedge CLK);
        serial_in = 1'b1;
        idle(20);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_rts", RTS, 1'b1);
        check("glitch_state", dut.state_q, IDLE);

        // 4a. Overrun: second frame arrives while the first is unread
        send_frame(8'h6B, 1'b1, 1'b1);
        expect_arrival("o1");
        idle(4);
        send_frame(8'h00, 1'b0, 1'b1);
        idle(2);
        check("ovr_valid", data_valid, 1'b1);
        check("ovr_data", data_out, 8'h6B);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_perr", parity_err, 1'b0);
        check("ovr_rts", RTS, 1'b0);
        pop();
        check("ovr_pop_valid", data_valid, 1'b0);
        check("ovr_pop_flag", overrun, 1'b0);
        check("ovr_pop_rts", RTS, 1'b1);
        idle(4);

        // 4b. Pop on the stop-sample edge: new byte taken, no overrun
        send_frame(8'h6B, 1'b1, 1'b1);
        expect_arrival("o2");
        idle(4);
        send_frame(8'h00, 1'b0, 1'b1);
        repeat (LAT - FRAME_BITS*CPB - 1) @(negedge CLK);
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
        check("sim_valid", data_valid, 1'b1);
        check("sim_data", data_out, 8'h00);
        check("sim_flag", overrun, 1'b0);
        check("sim_rts", RTS, 1'b0);
        pop();
        idle(4);

        // 5. Reset in the middle of DATA while a byte is held
        send_frame(8'h6B, 1'b1, 1'b1);
        expect_arrival("r0");
        idle(4);
        serial_in = 1'b0;
        idle(CPB);
        serial_in = 1'b1;
        idle(CPB);
        serial_in = 1'b0;
        idle(CPB);
        check("mid_state", dut.state_q, DATA);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", data_valid, 1'b0);
        check("mid_rst_rts", RTS, 1'b0);
        check("mid_rst_state", dut.state_q, IDLE);
        serial_in = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge CLK);
        check("mid_rel_rts", RTS, 1'b1);
        idle(4);
        send_frame(8'hA5, 1'b0, 1'b1);
        expect_arrival("r1");
        check("r1_data", data_out, 8'hA5);
        check("r1_perr", parity_err, 1'b0);
        check("r1_ferr", frame_err, 1'b0);
        check("r1_ovr", overrun, 1'b0);
        pop();
        idle(4);

        // 6. Flow-controlled loopback with a bench transmitter
        tx_fc(8'h6B, "lb1");
        check("lb1_data", data_out, 8'h6B);
        check("lb1_perr", parity_err, 1'b0);
        check("lb1_hold_rts", RTS, 1'b0);
        pop();
        tx_fc(8'h00, "lb2");
        check("lb2_data", data_out, 8'h00);
        check("lb2_perr", parity_err, 1'b0);
        check("lb2_ferr", frame_err, 1'b0);
        check("lb2_ovr", overrun, 1'b0);
        pop();
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
